// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: default widths,
// control-field layout and the zero-control bubble constant.
package pipe_pkg;

  // Default payload, control and bubble-counter widths
  localparam int unsigned DATA_W_DEF = 133;
  localparam int unsigned CTRL_W_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control-field bit positions (LSB first)
  localparam int unsigned CTRL_MEM_RD_BIT  = 0;
  localparam int unsigned CTRL_MEM_WR_BIT  = 1;
  localparam int unsigned CTRL_REG_WR_BIT  = 2;
  localparam int unsigned CTRL_ALU_OP_LSB  = 3;
  localparam int unsigned CTRL_ALU_OP_W    = 4;
  localparam int unsigned CTRL_ALU_SRC_BIT = 7;
  localparam int unsigned CTRL_BRANCH_BIT  = 8;
  localparam int unsigned CTRL_JUMP_BIT    = 9;

  // Packed view of the control field, matching the bit positions above
  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
  } ctrl_t;

  // A bubble carries no side effects: every control bit is zero
  localparam ctrl_t CTRL_BUBBLE = '0;

  // Buffer fill level encoding
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // True when a control word would have any architectural side effect
  function automatic logic ctrl_has_effect(input ctrl_t c);
    return c.mem_wr | c.reg_wr | c.branch | c.jump | c.mem_rd;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage buffer: valid flag, payload and control.
// Clear wins over load; clearing keeps the payload so data is stable on
// flush or when the slot drains.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Valid flag: clear has priority over load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // Payload and control: written only on a load that is not cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else if (i_load && !i_clr) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer with valid/ready handshake, stall hold, flush squash,
// gated bubble control and a saturating bubble counter.
// Build option: define PIPE_STAGE_SKID_EN for a two-entry (head + skid)
// buffer whose in_ready depends on registered state only.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              w_head_v;
  logic [DATA_W-1:0] w_head_data;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic              w_head_load;
  logic              w_head_clr;
  logic [DATA_W-1:0] w_head_in_data;
  logic [CTRL_W-1:0] w_head_in_ctrl;
  logic              w_accept;
  logic              w_consume;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // Handshake qualifiers; flush discards same-cycle input, stall blocks consume
  always_comb begin
    w_accept  = in_valid && in_ready && !flush;
    w_consume = w_head_v && out_ready && !stall;
  end

`ifdef PIPE_STAGE_SKID_EN

  logic              w_skid_v;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic              w_skid_load;
  logic              w_skid_clr;

  // Fill level from both slots
  always_comb begin
    occupancy = 2'(w_head_v) + 2'(w_skid_v);
  end

  // Ready from registered occupancy only; no out_ready path
  always_comb begin
    in_ready = rst_n && !stall && (occupancy != 2'(OCC_TWO));
  end

  // Head refills from skid on consume, otherwise from input; skid catches
  // an accept while the head is held
  always_comb begin
    w_head_load    = 1'b0;
    w_head_clr     = 1'b0;
    w_head_in_data = in_data;
    w_head_in_ctrl = in_ctrl;
    w_skid_load    = 1'b0;
    w_skid_clr     = 1'b0;
    if (flush) begin
      w_head_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else if (w_consume) begin
      if (w_skid_v) begin
        w_head_load    = 1'b1;
        w_head_in_data = w_skid_data;
        w_head_in_ctrl = w_skid_ctrl;
        w_skid_clr     = 1'b1;
      end else if (w_accept) begin
        w_head_load = 1'b1;
      end else begin
        w_head_clr = 1'b1;
      end
    end else if (w_accept) begin
      if (w_head_v) begin
        w_skid_load = 1'b1;
      end else begin
        w_head_load = 1'b1;
      end
    end
  end

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_skid_load),
    .i_clr  (w_skid_clr),
    .i_data (in_data),
    .i_ctrl (in_ctrl),
    .o_valid(w_skid_v),
    .o_data (w_skid_data),
    .o_ctrl (w_skid_ctrl)
  );

`else

  // Single slot: fill level is the head valid flag
  always_comb begin
    occupancy = {1'b0, w_head_v};
  end

  // Ready when not stalled and the head is empty or leaving this cycle
  always_comb begin
    in_ready = rst_n && !stall && (!w_head_v || out_ready);
  end

  // Accept overwrites the head (also when it is consumed in the same cycle)
  always_comb begin
    w_head_load    = 1'b0;
    w_head_clr     = 1'b0;
    w_head_in_data = in_data;
    w_head_in_ctrl = in_ctrl;
    if (flush) begin
      w_head_clr = 1'b1;
    end else if (w_accept) begin
      w_head_load = 1'b1;
    end else if (w_consume) begin
      w_head_clr = 1'b1;
    end
  end

`endif

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_head_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_head_load),
    .i_clr  (w_head_clr),
    .i_data (w_head_in_data),
    .i_ctrl (w_head_in_ctrl),
    .o_valid(w_head_v),
    .o_data (w_head_data),
    .o_ctrl (w_head_ctrl)
  );

  // Head presentation; control is forced to the bubble value when empty
  always_comb begin
    out_valid = w_head_v;
    out_data  = w_head_data;
    out_ctrl  = w_head_v ? w_head_ctrl : CTRL_W'(CTRL_BUBBLE);
  end

  // Saturating count of cycles where downstream was ready but starved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (out_ready && !w_head_v && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed + random bench for pipe_stage_buffer with a queue scoreboard.
module tb_pipe_stage_buffer;

  localparam int unsigned DW   = 133;
  localparam int unsigned CW   = 10;
  localparam int unsigned NW   = 4;
  localparam int          BMAX = 15;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          stall;
  logic          flush;
  logic [1:0]    occupancy;
  logic [NW-1:0] bubble_cnt;

  ent_t          sb[$];
  logic [DW-1:0] m_last;
  int            m_bub;
  int            n_total;
  int            n_pass;

  pipe_stage_buffer #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CNT_W (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    ed = (sb.size() != 0) ? sb[0].d : m_last;
    ec = (sb.size() != 0) ? sb[0].c : '0;
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(sb.size() != 0));
    chk({tag, ".out_data"}, out_data, ed);
    chk({tag, ".out_ctrl"}, DW'(out_ctrl), DW'(ec));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(sb.size()));
    chk({tag, ".bubble_cnt"}, DW'(bubble_cnt), DW'(m_bub));
  endtask

  // One clock of stimulus: drive at negedge, check ready, update model, check outputs
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy, input logic st,
                      input logic fl);
    logic exp_rdy;
    logic acc;
    logic cons;
    ent_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = !st && (sb.size() < 2);
`else
    exp_rdy = !st && ((sb.size() == 0) || ordy);
`endif
    chk({tag, ".in_ready"}, DW'(in_ready), DW'(exp_rdy));
    acc  = v && exp_rdy && !fl;
    cons = (sb.size() != 0) && ordy && !st;
    if (ordy && (sb.size() == 0) && (m_bub < BMAX)) m_bub++;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (cons) void'(sb.pop_front());
      if (acc) begin
        e.d = d;
        e.c = c;
        sb.push_back(e);
      end
    end
    if (sb.size() != 0) m_last = sb[0].d;
    check_outputs(tag);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    logic [DW-1:0] d_a5;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] held;
    int            bub_before;

    n_total   = 0;
    n_pass    = 0;
    m_last    = '0;
    m_bub     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    d_a5      = DW'({17{8'hA5}});
    d1        = DW'(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    d2        = DW'(128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678);

    // Reset holds everything at zero, before and across clock edges
    #3;
    check_outputs("reset_pre_clk");
    chk("reset_pre_clk.in_ready", DW'(in_ready), '0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held");
    chk("reset_held.in_ready", DW'(in_ready), '0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;

    // Single accept with one-cycle latency
    step("idle0", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step("acc_a5", 1'b1, d_a5, 10'h155, 1'b1, 1'b0, 1'b0);
    chk("acc_a5.data_latency", out_data, d_a5);
    bub_before = m_bub;
    step("cons_a5", 1'b1, ~d_a5, 10'h0AA, 1'b1, 1'b0, 1'b0);
    chk("cons_a5.bubble_unchanged", DW'(bubble_cnt), DW'(bub_before));
    step("drain", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step("bubble_ctrl", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Stall for three cycles with a valid head
    step("load_for_stall", 1'b1, d1, 10'h3FF, 1'b0, 1'b0, 1'b0);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, d2, 10'h001, 1'b1, 1'b1, 1'b0);
      chk("stall.data_held", out_data, held);
    end
    step("after_stall", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with input present and one entry held
    step("load_for_flush", 1'b1, d2, 10'h2A5, 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, d1, 10'h3C3, 1'b0, 1'b0, 1'b1);
    chk("flush.out_ctrl_zero", DW'(out_ctrl), '0);
    chk("flush.data_kept", out_data, d2);
    step("flush_stall", 1'b1, d1, 10'h001, 1'b1, 1'b1, 1'b1);

    // Two accepts while blocked, then drain in order
    step("ord_d1", 1'b1, d1, 10'h011, 1'b0, 1'b0, 1'b0);
    step("ord_d2", 1'b1, d2, 10'h022, 1'b0, 1'b0, 1'b0);
    step("ord_full", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("ord_full.head_d1", out_data, d1);
`ifdef PIPE_STAGE_SKID_EN
    chk("ord_full.occupancy_two", DW'(occupancy), DW'(2));
    chk("ord_full.in_ready_low", DW'(in_ready), '0);
`endif
    step("ord_pop1", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    chk("ord_pop1.head_d2", out_data, d2);
`endif
    step("ord_pop2", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 1)), rnd_data(), CW'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0));
    end

    // Starved for 20 cycles: counter saturates at its maximum
    step("sat_flush", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step("sat", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("sat.bubble_max", DW'(bubble_cnt), DW'(BMAX));
    step("sat_flush_keeps", 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("sat_flush_keeps.bubble", DW'(bubble_cnt), DW'(BMAX));

    // Asynchronous reset in the middle of traffic
    step("pre_rst_a", 1'b1, d1, 10'h155, 1'b0, 1'b0, 1'b0);
    step("pre_rst_b", 1'b1, d2, 10'h2AA, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_last = '0;
    m_bub  = 0;
    check_outputs("async_rst");
    chk("async_rst.in_ready", DW'(in_ready), '0);
    #2;
    rst_n = 1'b1;
    step("post_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step("post_rst_stall", 1'b1, d1, 10'h001, 1'b0, 1'b1, 1'b0);
    step("post_rst_acc", 1'b1, d_a5, 10'h0F0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
